// File: rtl/mux_8to1_scan_ctrl_if.sv
// Bus between the channel-scan controller and its surroundings.
// The controller drives the mux select lines and reports the assembled word.
// The requester drives start/cont/abort, and y comes back from the mux.
// Optional feature macro: MUX_SCAN_PARITY_EN adds the 'parity' signal.
interface mux_8to1_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic       abort;
  logic       y;
  logic       s0;
  logic       s1;
  logic       s2;
  logic       busy;
  logic [7:0] word;
  logic       word_valid;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity;

  modport master (
    output start, cont, abort, y,
    input  s0, s1, s2, busy, word, word_valid, parity
  );
  modport slave (
    input  start, cont, abort, y,
    output s0, s1, s2, busy, word, word_valid, parity
  );
`else
  modport master (
    output start, cont, abort, y,
    input  s0, s1, s2, busy, word, word_valid
  );
  modport slave (
    input  start, cont, abort, y,
    output s0, s1, s2, busy, word, word_valid
  );
`endif
endinterface

// File: rtl/mux_8to1_scan_ctrl.sv
// Channel scanner for an 8:1 mux.
// The controller steps the registered select through channels 0..7 and holds
// each channel for SETTLE cycles. It then samples y and publishes the eight
// samples as one word, together with a one-cycle word_valid pulse.
// Optional feature macro: MUX_SCAN_PARITY_EN adds an even-parity output
// that is loaded together with the word.
module mux_8to1_scan_ctrl #(
  parameter int unsigned SETTLE = 2  // legal range 1..15
) (
  input logic                  clk,
  input logic                  rst,
  mux_8to1_scan_ctrl_if.slave  bus
);

  localparam logic [3:0] SettleInit = 4'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] ch_q, ch_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] word_q, word_d;
  logic [2:0] sel_q, sel_d;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity_q, parity_d;
`endif

  // Next-state, channel/settle counters, capture shift and result word
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    word_d   = word_q;
`ifdef MUX_SCAN_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        // abort in IDLE only blocks a simultaneous start
        if (bus.start && !bus.abort) begin
          state_d = StSettle;
          ch_d    = 3'd0;
          cnt_d   = SettleInit;
        end
      end
      StSettle: begin
        if (bus.abort) begin
          state_d = StIdle;
          ch_d    = 3'd0;
          shift_d = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSample: begin
        if (bus.abort) begin
          state_d = StIdle;
          ch_d    = 3'd0;
          shift_d = '0;
        end else if (ch_q == 3'd7) begin
          // Last channel goes straight into the word, so it never lands in shift
          state_d  = StDone;
          word_d   = {bus.y, shift_q};
`ifdef MUX_SCAN_PARITY_EN
          parity_d = ^{bus.y, shift_q};
`endif
        end else begin
          shift_d[ch_q] = bus.y;
          ch_d          = ch_q + 3'd1;
          cnt_d         = SettleInit;
          state_d       = StSettle;
        end
      end
      StDone: begin
        if (bus.abort) begin
          state_d = StIdle;
          ch_d    = 3'd0;
          shift_d = '0;
        end else if (bus.cont) begin
          state_d = StSettle;
          ch_d    = 3'd0;
          cnt_d   = SettleInit;
        end else begin
          state_d = StIdle;
          ch_d    = 3'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The select register mirrors the channel only while a channel is being scanned
  always_comb begin
    sel_d = 3'd0;
    if (state_d == StSettle || state_d == StSample) begin
      sel_d = ch_d;
    end
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ch_q     <= 3'd0;
      cnt_q    <= 4'd0;
      shift_q  <= 7'd0;
      word_q   <= 8'h00;
      sel_q    <= 3'd0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      word_q   <= word_d;
      sel_q    <= sel_d;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.s0         = sel_q[0];
  assign bus.s1         = sel_q[1];
  assign bus.s2         = sel_q[2];
  assign bus.busy       = (state_q != StIdle);
  assign bus.word_valid = (state_q == StDone);
  assign bus.word       = word_q;
`ifdef MUX_SCAN_PARITY_EN
  assign bus.parity     = parity_q;
`endif

endmodule

// File: tb/tb_mux_8to1_scan_ctrl.sv
// Bench for mux_8to1_scan_ctrl: two instances are driven in parallel
// (SETTLE=2 and SETTLE=1). A scan-timeline model checks them every cycle, and
// directed checks use hand-computed literal expectations.
module tb_mux_8to1_scan_ctrl;

  localparam int S0 = 2;
  localparam int S1 = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] mux_in = 8'h00;
  logic       chk_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  mux_8to1_scan_ctrl_if bus0 ();
  mux_8to1_scan_ctrl_if bus1 ();

  assign bus0.start = start;
  assign bus0.cont  = cont;
  assign bus0.abort = abort;
  assign bus0.y     = mux_in[{bus0.s2, bus0.s1, bus0.s0}];
  assign bus1.start = start;
  assign bus1.cont  = cont;
  assign bus1.abort = abort;
  assign bus1.y     = mux_in[{bus1.s2, bus1.s1, bus1.s0}];

  mux_8to1_scan_ctrl #(.SETTLE(S0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mux_8to1_scan_ctrl #(.SETTLE(S1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t is the position on the scan timeline (0 = idle, 1..8*(S+1) = scanning,
  // 8*(S+1)+1 = result cycle). Channel k is sampled at t = (k+1)*(S+1).
  int         m_t[2] = '{0, 0};
  logic [7:0] cap[2] = '{8'h00, 8'h00};
  logic [7:0] m_word[2] = '{8'h00, 8'h00};

  function automatic int span(int i);
    return (i == 0) ? S0 + 1 : S1 + 1;
  endfunction

  function automatic logic [2:0] exp_sel(int t, int sp);
    if (t >= 1 && t <= 8 * sp) return 3'((t - 1) / sp);
    return 3'd0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int sp;
      int p;
      sp = span(i);
      p  = 8 * sp;
      if (rst) begin
        m_t[i]    = 0;
        m_word[i] = 8'h00;
      end else if (m_t[i] == 0) begin
        if (start && !abort) m_t[i] = 1;
      end else if (abort) begin
        m_t[i] = 0;
      end else if (m_t[i] == p + 1) begin
        m_t[i] = cont ? 1 : 0;
      end else begin
        if (m_t[i] % sp == 0) cap[i][m_t[i] / sp - 1] = mux_in[m_t[i] / sp - 1];
        if (m_t[i] == p) m_word[i] = cap[i];
        m_t[i] = m_t[i] + 1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("m0_busy", bus0.busy, m_t[0] != 0);
      check("m0_valid", bus0.word_valid, m_t[0] == 8 * span(0) + 1);
      check("m0_sel", {bus0.s2, bus0.s1, bus0.s0}, exp_sel(m_t[0], span(0)));
      check("m0_word", bus0.word, m_word[0]);
      check("m1_busy", bus1.busy, m_t[1] != 0);
      check("m1_valid", bus1.word_valid, m_t[1] == 8 * span(1) + 1);
      check("m1_sel", {bus1.s2, bus1.s1, bus1.s0}, exp_sel(m_t[1], span(1)));
      check("m1_word", bus1.word, m_word[1]);
`ifdef MUX_SCAN_PARITY_EN
      check("m0_parity", bus0.parity, ^m_word[0]);
      check("m1_parity", bus1.parity, ^m_word[1]);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  logic drop;

  initial begin
    run(2);
    chk_en = 1'b1;
    rst    = 1'b0;
    check("rst_busy", bus0.busy, 1'b0);
    check("rst_word", bus0.word, 8'h00);
    check("rst_valid", bus0.word_valid, 1'b0);

    // Single scan, SETTLE=2, data A5
    mux_in = 8'hA5;
    start  = 1'b1;
    step();                                   // cycle 1
    start  = 1'b0;
    check("a_sel_c1", {bus0.s2, bus0.s1, bus0.s0}, 3'd0);
    check("a_busy_c1", bus0.busy, 1'b1);
    run(3);                                   // cycle 4
    check("a_sel_c4", {bus0.s2, bus0.s1, bus0.s0}, 3'd1);
    run(18);                                  // cycle 22
    check("a_sel_c22", {bus0.s2, bus0.s1, bus0.s0}, 3'd7);
    run(2);                                   // cycle 24
    check("a_valid_c24", bus0.word_valid, 1'b0);
    step();                                   // cycle 25
    check("a_valid_c25", bus0.word_valid, 1'b1);
    check("a_word_c25", bus0.word, 8'hA5);
    step();                                   // cycle 26
    check("a_busy_c26", bus0.busy, 1'b0);
    check("a_word1", bus1.word, 8'hA5);

    // Abort at cycle 10 keeps the previous word
    mux_in = 8'h5A;
    start  = 1'b1;
    step();
    start  = 1'b0;
    run(9);                                   // cycle 10
    abort  = 1'b1;
    step();                                   // cycle 11
    abort  = 1'b0;
    check("ab_busy", bus0.busy, 1'b0);
    check("ab_sel", {bus0.s2, bus0.s1, bus0.s0}, 3'd0);
    check("ab_valid", bus0.word_valid, 1'b0);
    check("ab_word", bus0.word, 8'hA5);
    run(20);
    check("ab_word_late", bus0.word, 8'hA5);

    // start while busy is ignored; timing unchanged
    mux_in = 8'h0F;
    start  = 1'b1;
    step();                                   // cycle 1
    start  = 1'b0;
    run(4);                                   // cycle 5
    start  = 1'b1;
    step();                                   // cycle 6
    start  = 1'b0;
    run(19);                                  // cycle 25
    check("sb_valid", bus0.word_valid, 1'b1);
    check("sb_word", bus0.word, 8'h0F);
    step();
    check("sb_busy", bus0.busy, 1'b0);

    // start together with abort in IDLE stays idle
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy0", bus0.busy, 1'b0);
    check("sa_busy1", bus1.busy, 1'b0);
    run(2);

    // Continuous mode: 3C then C3
    mux_in = 8'h3C;
    cont   = 1'b1;
    start  = 1'b1;
    step();                                   // cycle 1
    start  = 1'b0;
    drop   = 1'b0;
    for (int c = 1; c < 25; c++) begin
      if (bus0.busy !== 1'b1) drop = 1'b1;
      step();
    end                                       // cycle 25
    check("c_valid25", bus0.word_valid, 1'b1);
    check("c_word25", bus0.word, 8'h3C);
    mux_in = 8'hC3;
    for (int c = 25; c < 50; c++) begin
      if (bus0.busy !== 1'b1) drop = 1'b1;
      step();
    end                                       // cycle 50
    check("c_valid50", bus0.word_valid, 1'b1);
    check("c_word50", bus0.word, 8'hC3);
    check("c_busy_held", drop, 1'b0);
    cont = 1'b0;
    run(30);
    check("c_idle", bus0.busy, 1'b0);

    // SETTLE=1 instance, data 81
    mux_in = 8'h81;
    start  = 1'b1;
    step();                                   // cycle 1
    start  = 1'b0;
    check("s1_sel_c1", {bus1.s2, bus1.s1, bus1.s0}, 3'd0);
    step();                                   // cycle 2
    check("s1_sel_c2", {bus1.s2, bus1.s1, bus1.s0}, 3'd0);
    step();                                   // cycle 3
    check("s1_sel_c3", {bus1.s2, bus1.s1, bus1.s0}, 3'd1);
    run(13);                                  // cycle 16
    check("s1_valid_c16", bus1.word_valid, 1'b0);
    step();                                   // cycle 17
    check("s1_valid_c17", bus1.word_valid, 1'b1);
    check("s1_word", bus1.word, 8'h81);
`ifdef MUX_SCAN_PARITY_EN
    check("s1_parity", bus1.parity, 1'b0);
`endif
    step();
    check("s1_busy_c18", bus1.busy, 1'b0);
    run(10);

    // Reset mid-scan
    mux_in = 8'hFF;
    start  = 1'b1;
    step();
    start  = 1'b0;
    run(7);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    check("r_busy", bus0.busy, 1'b0);
    check("r_sel", {bus0.s2, bus0.s1, bus0.s0}, 3'd0);
    check("r_word", bus0.word, 8'h00);
    check("r_valid", bus0.word_valid, 1'b0);
    check("r_word1", bus1.word, 8'h00);
    run(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
